// File: rtl/fft_pkg.sv
// Shared constants for the FFT subsystem: default frame geometry and channel owner codes.
package fft_pkg;
  localparam int   FFT_N     = 8;
  localparam int   FFT_DW    = 32;
  localparam int   FFT_CNT_W = $clog2(FFT_N);
  localparam logic CH0       = 1'b0;
  localparam logic CH1       = 1'b1;
endpackage

// File: rtl/fft_tag_fifo.sv
// Small 1-bit-wide FIFO holding the owner of each frame that has been granted to the FFT core
// but whose result frame has not yet been fully returned.
module fft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no control meaning until the count says an entry is live, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
endmodule

// File: rtl/fft_frame_arbiter.sv
// Shares one FFT core between two streaming channels, granting whole input frames round-robin
// and returning each result frame to its owner in grant order.
module fft_frame_arbiter
  import fft_pkg::*;
#(
  parameter int N_PT      = FFT_N,
  parameter int DW        = FFT_DW,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ch0_in_vld,
  output logic          ch0_in_rdy,
  input  logic [DW-1:0] ch0_in_data,
  input  logic          ch1_in_vld,
  output logic          ch1_in_rdy,
  input  logic [DW-1:0] ch1_in_data,
  output logic          core_in_vld,
  input  logic          core_in_rdy,
  output logic [DW-1:0] core_in_data,
  input  logic          core_out_vld,
  output logic          core_out_rdy,
  input  logic [DW-1:0] core_out_data,
  output logic          ch0_out_vld,
  input  logic          ch0_out_rdy,
  output logic [DW-1:0] ch0_out_data,
  output logic          ch1_out_vld,
  input  logic          ch1_out_rdy,
  output logic [DW-1:0] ch1_out_data,
  output logic          busy,
  output logic          tag_full,
  output logic          err_orphan
);
  localparam int CNT_W = $clog2(N_PT);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_PT - 1);

  logic [0:0]       state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             orphan_q;

  logic req, arb_owner, push, granted, in_fire, out_fire, pop;
  logic head, empty, full;

  assign req       = ch0_in_vld | ch1_in_vld;
  // A lone requester wins outright; on a tie the channel that did not win last time goes next.
  assign arb_owner = (ch0_in_vld & ch1_in_vld) ? ~last_grant : (ch1_in_vld ? CH1 : CH0);
  assign push      = (state == ST_IDLE) & req & ~full;
  assign granted   = (state == ST_GRANT);

  always_comb begin
    core_in_vld  = 1'b0;
    ch0_in_rdy   = 1'b0;
    ch1_in_rdy   = 1'b0;
    core_in_data = (owner == CH1) ? ch1_in_data : ch0_in_data;
    if (granted) begin
      if (owner == CH1) begin
        core_in_vld = ch1_in_vld;
        ch1_in_rdy  = core_in_rdy;
      end else begin
        core_in_vld = ch0_in_vld;
        ch0_in_rdy  = core_in_rdy;
      end
    end
  end

  always_comb begin
    core_out_rdy = 1'b0;
    ch0_out_vld  = 1'b0;
    ch1_out_vld  = 1'b0;
    if (!empty) begin
      if (head == CH1) begin
        ch1_out_vld  = core_out_vld;
        core_out_rdy = ch1_out_rdy;
      end else begin
        ch0_out_vld  = core_out_vld;
        core_out_rdy = ch0_out_rdy;
      end
    end
  end

  assign ch0_out_data = core_out_data;
  assign ch1_out_data = core_out_data;
  assign in_fire      = core_in_vld & core_in_rdy;
  assign out_fire     = core_out_vld & core_out_rdy;
  assign pop          = out_fire & (out_cnt == LAST_BEAT);
  assign busy         = granted | ~empty;
  assign tag_full     = full;
  assign err_orphan   = orphan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= CH0;
      last_grant <= CH1;
      in_cnt     <= '0;
      out_cnt    <= '0;
      orphan_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            state      <= ST_GRANT;
            owner      <= arb_owner;
            last_grant <= arb_owner;
            in_cnt     <= '0;
          end
        end
        default: begin
          if (in_fire) begin
            if (in_cnt == LAST_BEAT) begin
              state  <= ST_IDLE;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
      endcase
      if (out_fire) out_cnt <= pop ? '0 : out_cnt + 1'b1;
      if (core_out_vld & empty) orphan_q <= 1'b1;
    end
  end

  fft_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (arb_owner),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: a table-driven first-frame check, directed corner sequences and a
// randomized run, all compared against a frame-level reference model (owner queue + beat counts).
module tb_fft_frame_arbiter;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ch0_in_vld, ch0_in_rdy, ch1_in_vld, ch1_in_rdy;
  logic [DW-1:0] ch0_in_data, ch1_in_data;
  logic          core_in_vld, core_in_rdy, core_out_vld, core_out_rdy;
  logic [DW-1:0] core_in_data, core_out_data;
  logic          ch0_out_vld, ch0_out_rdy, ch1_out_vld, ch1_out_rdy;
  logic [DW-1:0] ch0_out_data, ch1_out_data;
  logic          busy, tag_full, err_orphan;

  int tests = 0;
  int fails = 0;

  fft_frame_arbiter #(.N_PT(N), .DW(DW), .TAG_DEPTH(TD)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch0_in_vld    (ch0_in_vld),
    .ch0_in_rdy    (ch0_in_rdy),
    .ch0_in_data   (ch0_in_data),
    .ch1_in_vld    (ch1_in_vld),
    .ch1_in_rdy    (ch1_in_rdy),
    .ch1_in_data   (ch1_in_data),
    .core_in_vld   (core_in_vld),
    .core_in_rdy   (core_in_rdy),
    .core_in_data  (core_in_data),
    .core_out_vld  (core_out_vld),
    .core_out_rdy  (core_out_rdy),
    .core_out_data (core_out_data),
    .ch0_out_vld   (ch0_out_vld),
    .ch0_out_rdy   (ch0_out_rdy),
    .ch0_out_data  (ch0_out_data),
    .ch1_out_vld   (ch1_out_vld),
    .ch1_out_rdy   (ch1_out_rdy),
    .ch1_out_data  (ch1_out_data),
    .busy          (busy),
    .tag_full      (tag_full),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  // Reference model: is a frame being accepted, who owns it, how many beats are in/out,
  // and the queue of owners whose results are still owed.
  bit m_granting, m_owner, m_last, m_orphan;
  int m_in_beats, m_out_beats;
  bit tagq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    m_granting  = 1'b0;
    m_owner     = 1'b0;
    m_last      = 1'b1;
    m_orphan    = 1'b0;
    m_in_beats  = 0;
    m_out_beats = 0;
    tagq.delete();
  endtask

  task automatic drive(input bit c0v, input bit c1v, input bit cir, input bit cov,
                       input bit c0r, input bit c1r);
    ch0_in_vld    = c0v;
    ch1_in_vld    = c1v;
    core_in_rdy   = cir;
    core_out_vld  = cov;
    ch0_out_rdy   = c0r;
    ch1_out_rdy   = c1r;
    ch0_in_data   = $urandom;
    ch1_in_data   = $urandom;
    core_out_data = $urandom;
  endtask

  task automatic check_model;
    logic e_civ, e_c0ir, e_c1ir, e_cor, e_c0ov, e_c1ov, src;
    src    = m_owner ? ch1_in_vld : ch0_in_vld;
    e_civ  = m_granting & src;
    e_c0ir = m_granting & !m_owner & core_in_rdy;
    e_c1ir = m_granting & m_owner & core_in_rdy;
    e_cor  = 1'b0;
    e_c0ov = 1'b0;
    e_c1ov = 1'b0;
    if (tagq.size() > 0) begin
      if (tagq[0]) begin
        e_c1ov = core_out_vld;
        e_cor  = ch1_out_rdy;
      end else begin
        e_c0ov = core_out_vld;
        e_cor  = ch0_out_rdy;
      end
    end
    chk("core_in_vld", core_in_vld, e_civ);
    chk("ch0_in_rdy", ch0_in_rdy, e_c0ir);
    chk("ch1_in_rdy", ch1_in_rdy, e_c1ir);
    if (m_granting) chk("core_in_data", core_in_data, m_owner ? ch1_in_data : ch0_in_data);
    chk("core_out_rdy", core_out_rdy, e_cor);
    chk("ch0_out_vld", ch0_out_vld, e_c0ov);
    chk("ch1_out_vld", ch1_out_vld, e_c1ov);
    chk("ch0_out_data", ch0_out_data, core_out_data);
    chk("ch1_out_data", ch1_out_data, core_out_data);
    chk("busy", busy, m_granting || tagq.size() > 0);
    chk("tag_full", tag_full, tagq.size() == TD);
    chk("err_orphan", err_orphan, m_orphan);
  endtask

  task automatic model_step;
    bit in_fire, out_fire, do_push, new_owner;
    int sz;
    sz       = tagq.size();
    in_fire  = m_granting && (m_owner ? ch1_in_vld : ch0_in_vld) && core_in_rdy;
    out_fire = (sz > 0) && core_out_vld && (tagq[0] ? ch1_out_rdy : ch0_out_rdy);
    do_push  = 1'b0;
    new_owner = 1'b0;
    if (core_out_vld && sz == 0) m_orphan = 1'b1;
    if (!m_granting && (ch0_in_vld || ch1_in_vld) && sz < TD) begin
      new_owner  = (ch0_in_vld && ch1_in_vld) ? !m_last : ch1_in_vld;
      m_last     = new_owner;
      m_owner    = new_owner;
      m_granting = 1'b1;
      m_in_beats = 0;
      do_push    = 1'b1;
    end else if (in_fire) begin
      m_in_beats++;
      if (m_in_beats == N) m_granting = 1'b0;
    end
    if (out_fire) begin
      m_out_beats++;
      if (m_out_beats == N) begin
        void'(tagq.pop_front());
        m_out_beats = 0;
      end
    end
    if (do_push) tagq.push_back(new_owner);
  endtask

  task automatic fin;
    check_model;
    model_step;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit c0v, input bit c1v, input bit cir, input bit cov,
                     input bit c0r, input bit c1r);
    drive(c0v, c1v, cir, cov, c0r, c1r);
    #2;
    fin;
  endtask

  function automatic logic [8:0] ctrl_outs();
    return {core_in_vld, ch0_in_rdy, ch1_in_rdy, core_out_rdy, ch0_out_vld, ch1_out_vld,
            busy, tag_full, err_orphan};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    model_reset;
    @(posedge clk);
    #1;
    chk("reset_outputs", ctrl_outs(), 9'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          c0v;
    logic [31:0] d;
    bit          e_civ;
    bit          e_rdy;
    logic [31:0] e_data;
    bit          e_busy;
  } vec_t;

  vec_t tv[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;

    // First frame after reset: ch0 granted, beats 0..7 forwarded in order.
    tv[0] = '{1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    for (int i = 1; i <= 8; i++) tv[i] = '{1'b1, 32'(i-1), 1'b1, 1'b1, 32'(i-1), 1'b1};
    tv[9] = '{1'b1, 32'd8, 1'b0, 1'b0, 32'd0, 1'b1};
    do_reset;
    for (int i = 0; i < 10; i++) begin
      ch0_in_vld = tv[i].c0v;  ch0_in_data = tv[i].d;
      ch1_in_vld = 1'b0;       core_in_rdy = 1'b1;
      core_out_vld = 1'b0;     ch0_out_rdy = 1'b1;  ch1_out_rdy = 1'b1;
      #2;
      chk("t1_core_in_vld", core_in_vld, tv[i].e_civ);
      chk("t1_ch0_in_rdy", ch0_in_rdy, tv[i].e_rdy);
      chk("t1_ch1_in_rdy", ch1_in_rdy, 1'b0);
      if (tv[i].e_civ) chk("t1_core_in_data", core_in_data, tv[i].e_data);
      chk("t1_busy", busy, tv[i].e_busy);
      @(posedge clk);
      #1;
    end

    // Both channels always valid: grants alternate 0,1,0,1 with one idle cycle between frames.
    do_reset;
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, 1'b1, 1'b1, tagq.size() > 0, 1'b1, 1'b1);
      #2;
      if (c % 9 == 1) chk("t2_alt_grant", {ch1_in_rdy, ch0_in_rdy}, ((c / 9) % 2) ? 2'b10 : 2'b01);
      fin;
    end

    // Core never returns: four grants fill the tag FIFO and a fifth is held off.
    do_reset;
    for (int c = 0; c < 45; c++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t3_tag_full", tag_full, 1'b1);
    chk("t3_no_grant", {core_in_vld, ch1_in_rdy, ch0_in_rdy}, 3'b000);
    fin;
    for (int c = 0; c < 8; c++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t3_full_cleared", tag_full, 1'b0);
    fin;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t3_next_grant", {ch1_in_rdy, ch0_in_rdy}, 2'b01);
    fin;

    // Stalled ch1 head blocks a ch0 result frame queued behind it.
    do_reset;
    for (int c = 0; c < 9; c++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t4_blocked", {core_out_rdy, ch0_out_vld, ch1_out_vld}, 3'b001);
      fin;
    end
    for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk("t4_ch0_turn", {core_out_rdy, ch0_out_vld, ch1_out_vld}, 3'b110);
    fin;

    // Last input beat and last output beat in one cycle with three tags outstanding.
    do_reset;
    for (int c = 0; c < 19; c++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk("t5_both_last", {ch0_in_rdy, core_out_rdy, ch0_out_vld, tag_full}, 4'b1110);
    fin;
    for (int c = 0; c < 10; c++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t5_refill_full", tag_full, 1'b1);
    fin;

    // Reset in the middle of a ch1 frame, then ch0 wins the next arbitration.
    do_reset;
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t6_beat5_live", ch1_in_rdy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_async_clear", ctrl_outs(), 9'h0);
    model_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("t6_ch0_after_rst", {ch1_in_rdy, ch0_in_rdy}, 2'b01);
    fin;

    // Result valid with nothing outstanding raises a sticky error.
    do_reset;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      chk("orphan_sticky", err_orphan, 1'b1);
      fin;
    end

    // Randomized traffic with stalls on every interface.
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          (tagq.size() > 0) && ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
